div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Scheduler that shares one iterative 32-bit divider between the two issue slots of the EXE stage, instead of giving each slot its own divider. Each slot holds a divide request until the stage advances. The block grants the divider in program order (slot 1 first), sequences the 32-step restoring divide and holds each slot's 64-bit {remainder, quotient} result with a done flag. A pipeline flush aborts it.

Parameters:
DW, 32, operand width; only 32 is supported and verified
CNT_W, 5, iteration counter width; must equal log2(DW)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
flush  input  1  pipeline clear (clear_all); aborts the current operation
es_go  input  1  EXE stage advances this cycle (ready_go & pms_allowin); releases done flags
s1_req  input  1  slot 1 has a divide (level, held while the bundle stays in EXE)
s1_signed  input  1  slot 1 signed divide
s1_dividend  input  DW  slot 1 rs value
s1_divisor  input  DW  slot 1 rt value
s2_req  input  1  slot 2 has a divide
s2_signed  input  1  slot 2 signed divide
s2_dividend  input  DW  slot 2 rs value (already forwarded)
s2_divisor  input  DW  slot 2 rt value
s1_done  output  1  slot 1 result valid
s1_res  output  2*DW  slot 1 {remainder[63:32], quotient[31:0]}
s2_done  output  1  slot 2 result valid
s2_res  output  2*DW  slot 2 result, same packing
busy  output  1  divider is occupied (state != IDLE)

Behaviour:
- Reset (async, resetn=0): state IDLE, counter 0, s1_done=s2_done=0, s1_res=s2_res=0, busy=0. Deassertion is used synchronously.
- States: IDLE, ITER, FIX.
- IDLE, one grant per edge:
  - s1_req & !s1_done: grant slot 1.
  - Else s2_req & !s2_done: grant slot 2.
  - On grant: latch |dividend|, |divisor| (abs only when signed), quotient sign, remainder sign and slot id; clear partial remainder and counter; go to ITER.
- ITER, 32 cycles:
  - Shift {rem, dividend} left by 1; trial-subtract the divisor.
  - If no borrow, keep the difference and set q bit = 1.
  - Counter increments; after count 31, go to FIX.
- FIX, 1 cycle:
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write the owning slot's res register and set its done flag; go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> done visible at cycle 34.
- Both slots requesting: slot 1 done at cycle 34, slot 2 granted at cycle 34, slot 2 done at cycle 68.
- Done flags: sticky until an edge with es_go=1, which clears both. es_go never aborts a running operation.
- Requests are sampled only at grant. Deasserting a request mid-operation does not cancel it; the operation completes and sets done.
- flush:
  - At the next edge, state -> IDLE, counter 0, both done flags cleared; res registers keep their values.
  - No grant on an edge where flush=1, even if a request is present.
- Divide by zero: no special case; the algorithm's natural output stands. Unsigned: q=FFFFFFFF, r=dividend. Signed: q=FFFFFFFF if dividend >= 0, otherwise 00000001; r=dividend. Timing is unchanged.
- Signed overflow 80000000/FFFFFFFF: q=80000000, r=0.
- busy is high in ITER and FIX.

Decomposition:
- Shared header (mycpu.h): state encodings and the DIV_RES_WD=64 packing macro; the {hi, lo} order must match the stage bus.
- One sub-module, div_iter_core: latched operands, the 32-step restoring loop and sign fix.
- div_share_ctrl keeps the FSM, grant logic, done/res registers and flush/es_go handling.

Test Plan:
- s1 unsigned 100/7, s2 idle -> s1_done rises at cycle 34, s1_res={00000002, 0000000E}; stays high until es_go; cleared on the es_go edge.
- Both slots signed, s1 -7/2, s2 7/-2 -> s1 at cycle 34: q=FFFFFFFD, r=FFFFFFFF; s2 at cycle 68: q=FFFFFFFD, r=00000001; es_go pulse after cycle 68 clears both.
- s1 unsigned 5/0 -> q=FFFFFFFF, r=00000005 at cycle 34. s1 signed 80000000/FFFFFFFF -> q=80000000, r=0.
- flush at cycle 10 of a slot 1 divide, with s1_req still high -> busy=0 next cycle, no done, old s1_res unchanged. Same-cycle flush+req -> no grant. Grant on the following edge -> done 34 cycles later.
- resetn low at cycle 20 mid-ITER (asynchronous, between edges) -> all outputs 0 immediately; after release, a fresh request completes normally.
- s1_req withdrawn at cycle 5 -> operation still completes, s1_done=1 at cycle 34. s2-only request -> slot 2 granted first, done at cycle 34.

Source files
------------

// File: rtl/div_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_share_ctrl_pkg
// Description : Shared types and constants for the shared EXE-stage divider:
//               FSM state encoding, slot identifiers and the result packing.
// Revision    : 1.0 - initial release
// ============================================================================
package div_share_ctrl_pkg;

  // Operand width and width of the packed {remainder, quotient} result
  localparam int c_div_dw     = 32;
  localparam int c_div_res_wd = 2 * c_div_dw;

  // Divider scheduler states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Owner of the operation currently in the divider
  typedef enum logic {
    SLOT_1 = 1'b0,
    SLOT_2 = 1'b1
  } div_slot_e;

  // The stage bus expects the remainder (hi) above the quotient (lo)
  function automatic logic [c_div_res_wd-1:0] pack_div_res(
    input logic [c_div_dw-1:0] rem,
    input logic [c_div_dw-1:0] quo
  );
    return {rem, quo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_share_ctrl_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : div_share_ctrl_iter_core
// Description : Iterative restoring divider datapath. Latches operand
//               magnitudes and result signs on load, performs one quotient
//               bit per step, and presents the sign-corrected result.
// Revision    : 1.0 - initial release
// ============================================================================
module div_share_ctrl_iter_core
  import div_share_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            signed_i,
  input  logic [DW-1:0]   dividend_i,
  input  logic [DW-1:0]   divisor_i,
  output logic [2*DW-1:0] res_o
);

  logic [DW-1:0] rem_q;   // partial remainder
  logic [DW-1:0] quo_q;   // dividend bits shift out, quotient bits shift in
  logic [DW-1:0] dsr_q;   // divisor magnitude
  logic          qneg_q;  // quotient must be negated
  logic          rneg_q;  // remainder takes a negative dividend's sign

  logic [DW-1:0] w_dvd_abs;
  logic [DW-1:0] w_dsr_abs;
  logic [DW:0]   w_trial;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_quo_fix;
  logic [DW-1:0] w_rem_fix;

  // Operand magnitudes (two's complement negation only for signed divides)
  // and the trial subtraction of one restoring step. w_diff[DW] is the borrow.
  always_comb begin
    w_dvd_abs = (signed_i && dividend_i[DW-1]) ? (-dividend_i) : dividend_i;
    w_dsr_abs = (signed_i && divisor_i[DW-1])  ? (-divisor_i)  : divisor_i;
    w_trial   = {rem_q, quo_q[DW-1]};
    w_diff    = w_trial - {1'b0, dsr_q};
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    w_quo_fix = qneg_q ? (-quo_q) : quo_q;
    w_rem_fix = rneg_q ? (-rem_q) : rem_q;
    res_o     = pack_div_res(w_rem_fix, w_quo_fix);
  end

  // Operand latch on load, one restoring iteration per step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= w_dvd_abs;
      dsr_q  <= w_dsr_abs;
      qneg_q <= signed_i && (dividend_i[DW-1] ^ divisor_i[DW-1]);
      rneg_q <= signed_i && dividend_i[DW-1];
    end else if (step_i) begin
      // No borrow: keep the difference and shift in a 1 quotient bit
      rem_q <= w_diff[DW] ? w_trial[DW-1:0] : w_diff[DW-1:0];
      quo_q <= {quo_q[DW-2:0], ~w_diff[DW]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_share_ctrl
// Description : Shares one iterative 32-bit divider between the two EXE issue
//               slots. Grants in program order, sequences the 32-step divide,
//               and holds per-slot results with sticky done flags that are
//               released when the stage advances. Flush aborts the divide.
// Revision    : 1.0 - initial release
// ============================================================================
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            es_go,
  input  logic            s1_req,
  input  logic            s1_signed,
  input  logic [DW-1:0]   s1_dividend,
  input  logic [DW-1:0]   s1_divisor,
  input  logic            s2_req,
  input  logic            s2_signed,
  input  logic [DW-1:0]   s2_dividend,
  input  logic [DW-1:0]   s2_divisor,
  output logic            s1_done,
  output logic [2*DW-1:0] s1_res,
  output logic            s2_done,
  output logic [2*DW-1:0] s2_res,
  output logic            busy
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  div_slot_e       slot_q;
  logic            s1_done_q;
  logic            s2_done_q;
  logic [2*DW-1:0] s1_res_q;
  logic [2*DW-1:0] s2_res_q;

  logic            w_grant1;
  logic            w_grant2;
  logic            w_grant;
  logic            w_step;
  logic            w_op_signed;
  logic [DW-1:0]   w_op_dividend;
  logic [DW-1:0]   w_op_divisor;
  logic [2*DW-1:0] w_core_res;

  // Grant in program order; a slot whose result is already held is skipped,
  // and nothing is granted on a flush edge.
  always_comb begin
    w_grant1      = (state_q == ST_IDLE) && !flush && s1_req && !s1_done_q;
    w_grant2      = (state_q == ST_IDLE) && !flush && !w_grant1 && s2_req && !s2_done_q;
    w_grant       = w_grant1 || w_grant2;
    w_step        = (state_q == ST_ITER) && !flush;
    w_op_signed   = w_grant2 ? s2_signed   : s1_signed;
    w_op_dividend = w_grant2 ? s2_dividend : s1_dividend;
    w_op_divisor  = w_grant2 ? s2_divisor  : s1_divisor;
  end

  div_share_ctrl_iter_core #(
    .DW (DW)
  ) u_core (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (w_grant),
    .step_i     (w_step),
    .signed_i   (w_op_signed),
    .dividend_i (w_op_dividend),
    .divisor_i  (w_op_divisor),
    .res_o      (w_core_res)
  );

  // Scheduler FSM with done/result registers; flush overrides everything,
  // a completing slot's done set wins over an es_go release on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      slot_q    <= SLOT_1;
      s1_done_q <= 1'b0;
      s2_done_q <= 1'b0;
      s1_res_q  <= '0;
      s2_res_q  <= '0;
    end else begin
      if (es_go) begin
        s1_done_q <= 1'b0;
        s2_done_q <= 1'b0;
      end
      if (flush) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        s1_done_q <= 1'b0;
        s2_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (w_grant) begin
              state_q <= ST_ITER;
              cnt_q   <= '0;
              slot_q  <= w_grant2 ? SLOT_2 : SLOT_1;
            end
          end
          ST_ITER: begin
            cnt_q <= cnt_q + c_cnt_one;
            if (cnt_q == c_cnt_last) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (slot_q == SLOT_1) begin
              s1_res_q  <= w_core_res;
              s1_done_q <= 1'b1;
            end else begin
              s2_res_q  <= w_core_res;
              s2_done_q <= 1'b1;
            end
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign s1_done = s1_done_q;
  assign s2_done = s2_done_q;
  assign s1_res  = s1_res_q;
  assign s2_res  = s2_res_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_share_ctrl
// Description : Scoreboard bench for div_share_ctrl. Stimulus pushes the
//               expected slot, result and completion cycle; a monitor pops
//               and compares on each rising done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        es_go;
  logic        s1_req, s1_signed, s2_req, s2_signed;
  logic [31:0] s1_dividend, s1_divisor, s2_dividend, s2_divisor;
  logic        s1_done, s2_done, busy;
  logic [63:0] s1_res, s2_res;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          slot;
    logic [63:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic p1 = 1'b0;
  logic p2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_share_ctrl #(.DW(32), .CNT_W(5)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .es_go       (es_go),
    .s1_req      (s1_req),
    .s1_signed   (s1_signed),
    .s1_dividend (s1_dividend),
    .s1_divisor  (s1_divisor),
    .s2_req      (s2_req),
    .s2_signed   (s2_signed),
    .s2_dividend (s2_dividend),
    .s2_divisor  (s2_divisor),
    .s1_done     (s1_done),
    .s1_res      (s1_res),
    .s2_done     (s2_done),
    .s2_res      (s2_res),
    .busy        (busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input int slot, input logic [63:0] res, input int c);
    exp_t e;
    e.slot = slot;
    e.res  = res;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic mon_pop(input int slot, input logic [63:0] res);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL done_unexpected: slot%0d res %h at cycle %0d, required no completion",
               slot, res, cyc);
    end else begin
      e = sb.pop_front();
      if (e.slot != slot || e.res !== res || e.cyc != cyc) begin
        fails++;
        $display("FAIL result: slot%0d res %h cycle %0d, required slot%0d res %h cycle %0d",
                 slot, res, cyc, e.slot, e.res, e.cyc);
      end
    end
  endtask

  // Monitor: compare on every rising done flag, away from the active edge
  always @(negedge clk) begin
    if (s1_done && !p1) mon_pop(1, s1_res);
    if (s2_done && !p2) mon_pop(2, s2_res);
    p1 = s1_done;
    p2 = s2_done;
  end

  // Drop requests and advance the stage; both done flags must clear
  task automatic release_stage();
    s1_req = 1'b0;
    s2_req = 1'b0;
    es_go  = 1'b1;
    tick(1);
    es_go  = 1'b0;
    chk("es_go_clear", {62'd0, s1_done, s2_done}, 64'd0);
  endtask

  task automatic run_s1(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    s1_signed   = sg;
    s1_dividend = a;
    s1_divisor  = b;
    s1_req      = 1'b1;
    push(1, exp, cyc + 34);
    tick(36);
    chk("s1_done_held", {63'd0, s1_done}, 64'd1);
    release_stage();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; es_go = 1'b0;
    s1_req = 1'b0; s1_signed = 1'b0; s1_dividend = '0; s1_divisor = '0;
    s2_req = 1'b0; s2_signed = 1'b0; s2_dividend = '0; s2_divisor = '0;
    tick(3);
    chk("reset_flags", {61'd0, s1_done, s2_done, busy}, 64'd0);
    chk("reset_s1_res", s1_res, 64'd0);
    chk("reset_s2_res", s2_res, 64'd0);
    resetn = 1'b1;
    tick(2);

    // Unsigned 100/7 on slot 1, sticky done, es_go release
    s1_signed = 1'b0; s1_dividend = 32'd100; s1_divisor = 32'd7; s1_req = 1'b1;
    push(1, {32'h00000002, 32'h0000000E}, cyc + 34);
    tick(1);
    chk("busy_in_iter", {63'd0, busy}, 64'd1);
    tick(39);
    chk("s1_done_sticky", {63'd0, s1_done}, 64'd1);
    chk("busy_idle_after", {63'd0, busy}, 64'd0);
    release_stage();

    // Both slots signed: -7/2 then 7/-2
    s1_signed = 1'b1; s1_dividend = 32'hFFFFFFF9; s1_divisor = 32'd2; s1_req = 1'b1;
    s2_signed = 1'b1; s2_dividend = 32'd7; s2_divisor = 32'hFFFFFFFE; s2_req = 1'b1;
    push(1, {32'hFFFFFFFF, 32'hFFFFFFFD}, cyc + 34);
    push(2, {32'h00000001, 32'hFFFFFFFD}, cyc + 68);
    tick(70);
    chk("both_done", {62'd0, s1_done, s2_done}, 64'd3);
    release_stage();

    // Boundary cases: divide by zero and signed overflow
    run_s1(1'b0, 32'd5, 32'd0, {32'h00000005, 32'hFFFFFFFF});
    run_s1(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
    run_s1(1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'h00000001});

    // Flush at cycle 10 with the request held; no grant on the flush edge
    s1_signed = 1'b0; s1_dividend = 32'd100; s1_divisor = 32'd7; s1_req = 1'b1;
    tick(10);
    flush = 1'b1;
    tick(1);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_no_done", {63'd0, s1_done}, 64'd0);
    tick(1);
    chk("flush_no_grant", {63'd0, busy}, 64'd0);
    chk("flush_res_kept", s1_res, {32'hFFFFFFFB, 32'h00000001});
    flush = 1'b0;
    push(1, {32'h00000002, 32'h0000000E}, cyc + 34);
    tick(36);
    chk("post_flush_done", {63'd0, s1_done}, 64'd1);
    release_stage();

    // Asynchronous reset mid-iteration
    s1_signed = 1'b0; s1_dividend = 32'd999; s1_divisor = 32'd3; s1_req = 1'b1;
    tick(20);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_flags", {61'd0, s1_done, s2_done, busy}, 64'd0);
    chk("async_rst_s1_res", s1_res, 64'd0);
    s1_req = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(1);
    run_s1(1'b0, 32'd1000, 32'd10, {32'h00000000, 32'h00000064});

    // Request withdrawn at cycle 5 still completes
    s1_signed = 1'b0; s1_dividend = 32'd12345; s1_divisor = 32'd100; s1_req = 1'b1;
    push(1, {32'h0000002D, 32'h0000007B}, cyc + 34);
    tick(5);
    s1_req = 1'b0;
    tick(31);
    chk("withdrawn_done", {63'd0, s1_done}, 64'd1);
    release_stage();

    // Slot 2 alone is granted immediately
    s2_signed = 1'b0; s2_dividend = 32'hFFFFFFFF; s2_divisor = 32'd16; s2_req = 1'b1;
    push(2, {32'h0000000F, 32'h0FFFFFFF}, cyc + 34);
    tick(36);
    chk("s2_only_flags", {62'd0, s1_done, s2_done}, 64'd1);
    release_stage();

    tick(2);
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
